// File: rtl/pwm_multichannel_pkg.sv
// rtl/pwm_multichannel_pkg.sv - shared mode enum and default parameters for the PWM block
package pwm_multichannel_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    localparam int DEF_NUM_CH  = 16;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_PRESC_W = 8;

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - prescaler, up/up-down counter and period boundary generation
module pwm_timebase
    import pwm_multichannel_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PRESC_W = DEF_PRESC_W
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   period,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               center_mode,
    output logic [CNT_W-1:0]   count,
    output logic               boundary,
    output logic               period_start
);

    logic [PRESC_W-1:0] presc_cnt;
    logic [CNT_W-1:0]   period_act;
    logic [CNT_W-1:0]   count_next;
    pwm_mode_e          mode_act;
    logic               dir_down;
    logic               dir_down_next;
    logic               tick;

    // >= rather than == so a prescale lowered below the running count wraps at once
    assign tick = (presc_cnt >= prescale);

    always_comb begin
        count_next    = count;
        dir_down_next = dir_down;
        if (period_act == '0) begin
            count_next    = '0;
            dir_down_next = 1'b0;
        end else if (mode_act == PWM_EDGE) begin
            count_next    = (count >= period_act) ? '0 : count + 1'b1;
            dir_down_next = 1'b0;
        end else if (dir_down || (count >= period_act)) begin
            count_next    = count - 1'b1;
            dir_down_next = (count != CNT_W'(1));
        end else begin
            count_next    = count + 1'b1;
        end
    end

    assign boundary = tick && (count_next == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt    <= '0;
            count        <= '0;
            dir_down     <= 1'b0;
            period_act   <= '0;
            mode_act     <= PWM_EDGE;
            period_start <= 1'b0;
        end else begin
            presc_cnt    <= tick ? '0 : presc_cnt + 1'b1;
            period_start <= boundary;
            if (tick) begin
                count    <= count_next;
                dir_down <= dir_down_next;
                if (boundary) begin
                    period_act <= period;
                    mode_act   <= pwm_mode_e'(center_mode);
                    dir_down   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_multichannel.sv
// rtl/pwm_multichannel.sv - multichannel PWM with shadowed duty registers and shared timebase
module pwm_multichannel
    import pwm_multichannel_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PRESC_W = DEF_PRESC_W,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CH-1:0]  en_out,
    input  logic [NUM_CH-1:0]  en_pwm,
    input  logic               duty_wr_en,
    input  logic [CH_W-1:0]    duty_wr_ch,
    input  logic [CNT_W-1:0]   duty_wr_data,
    input  logic [CNT_W-1:0]   period,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               center_mode,
    output logic [NUM_CH-1:0]  out,
    output logic               period_start
);

    logic [CNT_W-1:0]  shadow   [NUM_CH];
    logic [CNT_W-1:0]  duty_act [NUM_CH];
    logic [CNT_W-1:0]  count;
    logic              boundary;
    logic [NUM_CH-1:0] pwm_raw;

    pwm_timebase #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk          (clk),
        .rst          (rst),
        .period       (period),
        .prescale     (prescale),
        .center_mode  (center_mode),
        .count        (count),
        .boundary     (boundary),
        .period_start (period_start)
    );

    always_comb begin
        pwm_raw = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_raw[i] = (count < duty_act[i]);
        end
    end

    // Active duties latch the pre-write shadow, so a write on the boundary waits one more period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i]   <= '0;
                duty_act[i] <= '0;
            end
            out <= '0;
        end else begin
            if (boundary) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    duty_act[i] <= shadow[i];
                end
            end
            if (duty_wr_en && (32'(duty_wr_ch) < NUM_CH)) begin
                shadow[duty_wr_ch] <= duty_wr_data;
            end
            out <= en_out & (~en_pwm | pwm_raw);
        end
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// tb/tb_pwm_multichannel.sv - directed and random checks of pwm_multichannel against a phase model
module tb_pwm_multichannel;

    localparam int NUM_CH  = 6;
    localparam int CNT_W   = 8;
    localparam int PRESC_W = 4;
    localparam int CH_W    = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_CH-1:0]  en_out;
    logic [NUM_CH-1:0]  en_pwm;
    logic               duty_wr_en;
    logic [CH_W-1:0]    duty_wr_ch;
    logic [CNT_W-1:0]   duty_wr_data;
    logic [CNT_W-1:0]   period;
    logic [PRESC_W-1:0] prescale;
    logic               center_mode;
    logic [NUM_CH-1:0]  out;
    logic               period_start;

    int errors = 0;
    int checks = 0;

    // Model: position within the current period, plus active/shadow duty tables
    int m_pc, m_pos, m_period;
    bit m_center;
    int m_duty   [NUM_CH];
    int m_shadow [NUM_CH];

    pwm_multichannel #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_out       (en_out),
        .en_pwm       (en_pwm),
        .duty_wr_en   (duty_wr_en),
        .duty_wr_ch   (duty_wr_ch),
        .duty_wr_data (duty_wr_data),
        .period       (period),
        .prescale     (prescale),
        .center_mode  (center_mode),
        .out          (out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    function automatic int m_len();
        if (m_period == 0) return 1;
        return m_center ? 2 * m_period : m_period + 1;
    endfunction

    function automatic int m_cnt();
        if (m_center && (m_pos > m_period)) return 2 * m_period - m_pos;
        return m_pos;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_pos = 0; m_period = 0; m_center = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_duty[i]   = 0;
            m_shadow[i] = 0;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [NUM_CH-1:0] exp_out;
        bit tick, bnd;
        int cnt;
        cnt = m_cnt();
        for (int i = 0; i < NUM_CH; i++)
            exp_out[i] = en_out[i] & (en_pwm[i] ? (cnt < m_duty[i]) : 1'b1);
        tick = (m_pc >= int'(prescale));
        bnd  = tick && (m_pos + 1 == m_len());
        @(posedge clk);
        #1;
        checks++;
        assert (out === exp_out) else begin
            errors++;
            $error("FAIL out: observed=%b expected=%b", out, exp_out);
        end
        checks++;
        assert (period_start === bnd) else begin
            errors++;
            $error("FAIL period_start: observed=%b expected=%b", period_start, bnd);
        end
        m_pc = tick ? 0 : m_pc + 1;
        if (tick) m_pos = bnd ? 0 : m_pos + 1;
        if (bnd) begin
            for (int i = 0; i < NUM_CH; i++) m_duty[i] = m_shadow[i];
            m_period = int'(period);
            m_center = center_mode;
        end
        if (duty_wr_en && (int'(duty_wr_ch) < NUM_CH))
            m_shadow[duty_wr_ch] = int'(duty_wr_data);
    endtask

    task automatic run(input int n, input int ch, output int hi, output int ps);
        hi = 0; ps = 0;
        repeat (n) begin
            step();
            hi += int'(out[ch]);
            ps += int'(period_start);
        end
    endtask

    task automatic wr(input int ch, input int d);
        duty_wr_en   = 1'b1;
        duty_wr_ch   = CH_W'(ch);
        duty_wr_data = CNT_W'(d);
        step();
        duty_wr_en   = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step();
            seen = period_start;
        end
        check(tag, int'(seen), 1);
    endtask

    initial begin
        int hi, ps;
        rst = 1'b1; en_out = '0; en_pwm = '0; duty_wr_en = 1'b0; duty_wr_ch = '0;
        duty_wr_data = '0; period = '0; prescale = '0; center_mode = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", int'(out), 0);
        check("reset_period_start", int'(period_start), 0);
        rst = 1'b0;

        // Edge-aligned, period 9
        en_out = '1; en_pwm = '1; period = 9;
        wr(0, 3); wr(1, 2); wr(2, 2);
        run(30, 0, hi, ps);
        run(10, 0, hi, ps);
        check("edge_high", hi, 3);
        check("edge_starts", ps, 1);

        // Center-aligned, period 4: counter 0,1,2,3,4,3,2,1
        center_mode = 1'b1; period = 4;
        run(30, 1, hi, ps);
        run(8, 1, hi, ps);
        check("center_high", hi, 3);
        check("center_starts", ps, 1);

        // Prescaled, period 1
        center_mode = 1'b0; period = 1; prescale = 3;
        wr(0, 1);
        run(40, 0, hi, ps);
        run(8, 0, hi, ps);
        check("presc_high", hi, 4);
        check("presc_starts", ps, 1);

        // Mid-period write, then write coincident with a boundary
        prescale = 0; period = 9;
        run(30, 2, hi, ps);
        while (m_pos != 4) step();
        wr(2, 5);
        wait_start("mid_write_start");
        run(10, 2, hi, ps);
        check("mid_write_high", hi, 5);
        while (!((m_pc >= int'(prescale)) && (m_pos + 1 == m_len()))) step();
        wr(2, 7);
        run(10, 2, hi, ps);
        check("bnd_write_old", hi, 5);
        run(10, 2, hi, ps);
        check("bnd_write_new", hi, 7);

        // Static cases and an out-of-range write
        wr(3, 0); wr(4, 200); wr(6, 99);
        en_pwm[5] = 1'b0; en_out[0] = 1'b0;
        run(30, 3, hi, ps);
        run(10, 3, hi, ps); check("duty0_low", hi, 0);
        run(10, 4, hi, ps); check("duty200_high", hi, 10);
        run(10, 5, hi, ps); check("en_pwm0_high", hi, 10);
        run(10, 0, hi, ps); check("en_out0_low", hi, 0);
        run(10, 1, hi, ps); check("oob_write_ch1", hi, 2);

        // Random configuration churn
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(39) == 0) prescale = PRESC_W'($urandom_range(3));
            if ($urandom_range(29) == 0) period = CNT_W'($urandom_range(12));
            if ($urandom_range(29) == 0) center_mode = 1'($urandom_range(1));
            if ($urandom_range(19) == 0) en_out = NUM_CH'($urandom);
            if ($urandom_range(19) == 0) en_pwm = NUM_CH'($urandom);
            duty_wr_en   = ($urandom_range(3) == 0);
            duty_wr_ch   = CH_W'($urandom_range(7));
            duty_wr_data = CNT_W'($urandom_range(15));
            step();
        end
        duty_wr_en = 1'b0;

        // Asynchronous reset mid-period drops pending shadow writes
        prescale = 0; period = 9; center_mode = 1'b0; en_out = '1; en_pwm = 6'b011111;
        run(25, 5, hi, ps);
        while (m_pos != 3) step();
        wr(1, 9);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out", int'(out), 0);
        check("async_rst_period_start", int'(period_start), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        en_pwm = '1;
        run(30, 1, hi, ps);
        run(10, 1, hi, ps);
        check("post_rst_duty", hi, 0);
        check("post_rst_out", int'(out), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
